fifodual_enq_sched: RTL and testbench
=====================================

Name: fifodual_enq_sched

Overview:
- Credit-based enqueue scheduler that shares one dual-enqueue FIFO (ports A and B, single dequeue) among NREQ requesters.
- Each cycle it grants up to two requesters in round-robin order and drives the FIFO's A/B enqueue ports from a registered output stage.
- It tracks FIFO occupancy internally with a credit counter, so it never over-fills the FIFO, and it flags protocol errors.
- It sits directly in front of the FIFO enqueue side; the dequeue side reports each pop back through deq_fire.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DWIDTH, 64, data width per entry.
- QUEUE_SIZE, 21, FIFO capacity in entries; equals the initial credit count.
- CWIDTH, $clog2(QUEUE_SIZE+1), credit counter width (derived; do not override).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NREQ  requester i has an entry to enqueue.
- req_data  in  NREQ*DWIDTH  requester i data in slice [i*DWIDTH +: DWIDTH].
- req_ready  out  NREQ  combinational grant; transfer when req_valid[i] & req_ready[i].
- inA_enque_en  out  1  registered enqueue strobe, FIFO port A.
- inA_data  out  DWIDTH  registered data, port A.
- inB_enque_en  out  1  registered enqueue strobe, FIFO port B.
- inB_data  out  DWIDTH  registered data, port B.
- fifo_in_valid  in  1  FIFO accept indication; used only for error checking.
- deq_fire  in  1  one entry left the FIFO this cycle (out_deque_en & out_valid).
- credits  out  CWIDTH  current free-entry count.
- enq_total  out  32  wrapping count of entries enqueued.
- err  out  2  sticky; bit0 overflow, bit1 credit underflow.

Behaviour:
- Reset (async, rst=1):
  - credits=QUEUE_SIZE; rr_ptr=0.
  - inA/inB_enque_en=0, inA/inB_data=0.
  - enq_total=0, err=0, req_ready=0 while rst high.
  - Any in-flight registered enqueue is discarded.
- Grant budget per cycle: min(2, credits, popcount(req_valid)). deq_fire in the same cycle does not raise the budget.
- Grant selection:
  - Scan requesters starting at rr_ptr, wrapping modulo NREQ.
  - The first valid requester found goes to port A; the second goes to port B.
  - A single grant always uses port A, never B.
- rr_ptr update: set to (index of last granted requester + 1) mod NREQ; unchanged if there were no grants.
- Latency: a grant in cycle t makes inX_enque_en=1 with the captured data in cycle t+1. The strobe is high for exactly one cycle per grant; data holds its last value when the strobe is low.
- Credits:
  - credits_next = credits - grants + deq_fire.
  - Credits are decremented at grant time, so in-flight entries are already accounted for.
  - Invariant: 0 <= credits <= QUEUE_SIZE.
- Boundaries:
  - credits=0: no grants, req_ready=0.
  - credits=1: at most one grant, on port A.
  - deq_fire with credits=QUEUE_SIZE and no grant: set err[1]; credits saturate at QUEUE_SIZE.
  - inA_enque_en|inB_enque_en high while fifo_in_valid=0: set err[0]. The enqueue is still presented.
- enq_total adds the number of strobes asserted each cycle (0, 1 or 2) and wraps at 2^32.
- err bits clear only on reset.

Decomposition:
- Package fifodual_pkg holds:
  - DWIDTH_DEF and QUEUE_SIZE_DEF defaults.
  - typedef enq_port_t {PORT_A, PORT_B}.
  - Error bit index constants ERR_OVF=0, ERR_UNF=1.
- One sub-module, rr_pick2: a combinational round-robin finder.
  - Inputs: req vector, rr_ptr, budget.
  - Outputs: grantA/grantB one-hot vectors, validA/validB, and the next pointer.
- The top level holds the credit counter, output registers, statistics and error logic.

Test Plan:
- Reset then idle (NREQ=4, QUEUE_SIZE=21) -> credits=21, both strobes 0, err=0, enq_total=0.
- req_valid=4'b1111, rr_ptr=0, no dequeues -> cycle0 grants req0→A and req1→B, cycle1 grants req2→A and req3→B, rr_ptr returns to 0. Strobes follow one cycle after each grant. Credits fall by 2 per cycle and reach 0 after 11 cycles, with the 11th cycle granting only one (port A). Thereafter req_ready=0 and enq_total=21.
- Credits=0 with deq_fire pulsed once -> next cycle exactly one grant on port A, credits return to 0, no err.
- Simultaneous 2 grants and deq_fire with credits=5 -> credits=4 next cycle.
- deq_fire at credits=21 with no grants -> err=2'b10, credits stay 21. Then drive a strobe while fifo_in_valid=0 -> err=2'b11.
- Assert rst mid-burst with a strobe pending -> strobes drop immediately, credits=21, rr_ptr=0, and the discarded entry is not counted in enq_total.

Source files
------------

// File: rtl/fifodual_pkg.sv
// Shared definitions for the dual-enqueue FIFO scheduler.
package fifodual_pkg;

  localparam int DWIDTH_DEF     = 64;
  localparam int QUEUE_SIZE_DEF = 21;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } enq_port_t;

  localparam int ERR_OVF = 0;
  localparam int ERR_UNF = 1;

endpackage

// File: rtl/fifodual_enq_sched_rr_pick2.sv
// Combinational round-robin finder: picks up to two requesters starting at
// the pointer, first hit to port A, second to port B, limited by budget.
module rr_pick2
  import fifodual_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_rr_ptr,
  input  logic [1:0]      i_budget,
  output logic [NREQ-1:0] o_grant_a,
  output logic [NREQ-1:0] o_grant_b,
  output logic            o_valid_a,
  output logic            o_valid_b,
  output logic [PW-1:0]   o_next_ptr
);

  logic [NREQ-1:0] w_grant_a;
  logic [NREQ-1:0] w_grant_b;
  logic            w_valid_a;
  logic            w_valid_b;
  logic [PW:0]     w_sum;
  logic [PW-1:0]   w_idx;
  logic [PW-1:0]   w_last;
  logic [PW-1:0]   w_next;

  // Scan requesters from the pointer with wrap, assigning A then B.
  always_comb begin
    w_grant_a = '0;
    w_grant_b = '0;
    w_valid_a = 1'b0;
    w_valid_b = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    w_last    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, i_rr_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NREQ)) begin
        w_sum = w_sum - (PW+1)'(NREQ);
      end else begin
        w_sum = w_sum;
      end
      w_idx = w_sum[PW-1:0];
      if (i_req[w_idx]) begin
        if (!w_valid_a) begin
          if (i_budget != 2'd0) begin
            w_grant_a[w_idx] = 1'b1;
            w_valid_a        = 1'b1;
            w_last           = w_idx;
          end else begin
            w_valid_a = 1'b0;
          end
        end else if (!w_valid_b) begin
          if (i_budget == 2'd2) begin
            w_grant_b[w_idx] = 1'b1;
            w_valid_b        = 1'b1;
            w_last           = w_idx;
          end else begin
            w_valid_b = 1'b0;
          end
        end else begin
          w_valid_b = w_valid_b;
        end
      end else begin
        w_idx = w_idx;
      end
    end
  end

  // Next pointer follows the last granted requester; hold when idle.
  always_comb begin
    w_next = i_rr_ptr;
    if (w_valid_a) begin
      if (w_last == PW'(NREQ-1)) begin
        w_next = '0;
      end else begin
        w_next = w_last + PW'(1);
      end
    end else begin
      w_next = i_rr_ptr;
    end
  end

  assign o_grant_a  = w_grant_a;
  assign o_grant_b  = w_grant_b;
  assign o_valid_a  = w_valid_a;
  assign o_valid_b  = w_valid_b;
  assign o_next_ptr = w_next;

endmodule

// File: rtl/fifodual_enq_sched.sv
// Credit-based dual-port enqueue scheduler in front of a shared FIFO.
// Credits are taken at grant time so in-flight entries are already counted.
module fifodual_enq_sched
  import fifodual_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DWIDTH     = DWIDTH_DEF,
  parameter int QUEUE_SIZE = QUEUE_SIZE_DEF,
  parameter int CWIDTH     = $clog2(QUEUE_SIZE+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     inA_enque_en,
  output logic [DWIDTH-1:0]        inA_data,
  output logic                     inB_enque_en,
  output logic [DWIDTH-1:0]        inB_data,
  input  logic                     fifo_in_valid,
  input  logic                     deq_fire,
  output logic [CWIDTH-1:0]        credits,
  output logic [31:0]              enq_total,
  output logic [1:0]               err
);

  localparam int PW = $clog2(NREQ);

  logic [CWIDTH-1:0] r_credits;
  logic [PW-1:0]     r_rr_ptr;
  logic              r_a_en;
  logic              r_b_en;
  logic [DWIDTH-1:0] r_a_data;
  logic [DWIDTH-1:0] r_b_data;
  logic [31:0]       r_enq_total;
  logic [1:0]        r_err;

  logic [1:0]        w_budget;
  logic [NREQ-1:0]   w_grant_a;
  logic [NREQ-1:0]   w_grant_b;
  logic              w_valid_a;
  logic              w_valid_b;
  logic [PW-1:0]     w_next_ptr;
  logic [NREQ-1:0]   w_ready;
  logic [DWIDTH-1:0] w_data_a;
  logic [DWIDTH-1:0] w_data_b;
  logic [1:0]        w_ngrant;
  logic [CWIDTH:0]   w_cr_ext;
  logic [CWIDTH-1:0] w_cr_next;
  logic              w_unf;
  logic              w_ovf;

  // Grant budget is min(2, credits); a same-cycle dequeue does not add to it.
  always_comb begin
    w_budget = 2'd0;
    if (r_credits >= CWIDTH'(2)) begin
      w_budget = 2'd2;
    end else if (r_credits == CWIDTH'(1)) begin
      w_budget = 2'd1;
    end else begin
      w_budget = 2'd0;
    end
  end

  rr_pick2 #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_req      (req_valid),
    .i_rr_ptr   (r_rr_ptr),
    .i_budget   (w_budget),
    .o_grant_a  (w_grant_a),
    .o_grant_b  (w_grant_b),
    .o_valid_a  (w_valid_a),
    .o_valid_b  (w_valid_b),
    .o_next_ptr (w_next_ptr)
  );

  // Ready is the grant itself, forced low while reset is asserted.
  always_comb begin
    w_ready = '0;
    if (rst) begin
      w_ready = '0;
    end else begin
      w_ready = w_grant_a | w_grant_b;
    end
  end

  // Select the granted requesters' data from the one-hot grants.
  always_comb begin
    w_data_a = '0;
    w_data_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_a[i]) begin
        w_data_a = w_data_a | req_data[i*DWIDTH +: DWIDTH];
      end else begin
        w_data_a = w_data_a;
      end
      if (w_grant_b[i]) begin
        w_data_b = w_data_b | req_data[i*DWIDTH +: DWIDTH];
      end else begin
        w_data_b = w_data_b;
      end
    end
  end

  // Next credit value; a dequeue report with a full credit pool is an error
  // and the counter saturates instead of exceeding the FIFO size.
  always_comb begin
    w_ngrant  = {1'b0, w_valid_a} + {1'b0, w_valid_b};
    w_unf     = deq_fire && (r_credits == CWIDTH'(QUEUE_SIZE)) && !w_valid_a;
    w_ovf     = (r_a_en || r_b_en) && !fifo_in_valid;
    w_cr_ext  = '0;
    w_cr_next = r_credits;
    if (w_unf) begin
      w_cr_next = r_credits;
    end else begin
      w_cr_ext  = {1'b0, r_credits} - (CWIDTH+1)'(w_ngrant)
                  + (CWIDTH+1)'(deq_fire);
      w_cr_next = w_cr_ext[CWIDTH-1:0];
    end
  end

  // Credit counter and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits <= CWIDTH'(QUEUE_SIZE);
      r_rr_ptr  <= '0;
    end else begin
      r_credits <= w_cr_next;
      r_rr_ptr  <= w_next_ptr;
    end
  end

  // Registered enqueue stage; data holds when the strobe is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_en   <= 1'b0;
      r_b_en   <= 1'b0;
      r_a_data <= '0;
      r_b_data <= '0;
    end else begin
      r_a_en <= w_valid_a;
      r_b_en <= w_valid_b;
      if (w_valid_a) begin
        r_a_data <= w_data_a;
      end else begin
        r_a_data <= r_a_data;
      end
      if (w_valid_b) begin
        r_b_data <= w_data_b;
      end else begin
        r_b_data <= r_b_data;
      end
    end
  end

  // Enqueue statistics and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enq_total <= 32'd0;
      r_err       <= 2'b00;
    end else begin
      r_enq_total <= r_enq_total + {31'd0, r_a_en} + {31'd0, r_b_en};
      if (w_ovf) begin
        r_err[ERR_OVF] <= 1'b1;
      end else begin
        r_err[ERR_OVF] <= r_err[ERR_OVF];
      end
      if (w_unf) begin
        r_err[ERR_UNF] <= 1'b1;
      end else begin
        r_err[ERR_UNF] <= r_err[ERR_UNF];
      end
    end
  end

  assign req_ready    = w_ready;
  assign inA_enque_en = r_a_en;
  assign inA_data     = r_a_data;
  assign inB_enque_en = r_b_en;
  assign inB_data     = r_b_data;
  assign credits      = r_credits;
  assign enq_total    = r_enq_total;
  assign err          = r_err;

endmodule

// File: tb/tb_fifodual_enq_sched.sv
// Directed bench for fifodual_enq_sched (NREQ=4, QUEUE_SIZE=21).
module tb_fifodual_enq_sched;

  localparam int NREQ = 4;
  localparam int DW   = 64;
  localparam int QS   = 21;
  localparam int CW   = $clog2(QS+1);

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              inA_enque_en;
  logic [DW-1:0]     inA_data;
  logic              inB_enque_en;
  logic [DW-1:0]     inB_data;
  logic              fifo_in_valid;
  logic              deq_fire;
  logic [CW-1:0]     credits;
  logic [31:0]       enq_total;
  logic [1:0]        err;

  int n_checks = 0;
  int n_pass   = 0;

  fifodual_enq_sched #(
    .NREQ(NREQ), .DWIDTH(DW), .QUEUE_SIZE(QS)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .inA_enque_en(inA_enque_en), .inA_data(inA_data),
    .inB_enque_en(inB_enque_en), .inB_data(inB_data),
    .fifo_in_valid(fifo_in_valid), .deq_fire(deq_fire), .credits(credits),
    .enq_total(enq_total), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dat(input int k);
    return 64'h1111_1111_1111_1111 * (k + 1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] rv;
    logic       deq;
    logic [3:0] exp_ready;
    logic       exp_a;
    int         a_idx;
    logic       exp_b;
    int         b_idx;
    int         exp_cr;
  } vec_t;

  vec_t vecs[20];

  initial begin
    // burst from full credits, ptr 0
    vecs[0]  = '{4'hF, 1'b0, 4'h3, 1'b1, 0, 1'b1, 1, 19};
    vecs[1]  = '{4'hF, 1'b0, 4'hC, 1'b1, 2, 1'b1, 3, 17};
    vecs[2]  = '{4'hF, 1'b0, 4'h3, 1'b1, 0, 1'b1, 1, 15};
    vecs[3]  = '{4'hF, 1'b0, 4'hC, 1'b1, 2, 1'b1, 3, 13};
    vecs[4]  = '{4'hF, 1'b0, 4'h3, 1'b1, 0, 1'b1, 1, 11};
    vecs[5]  = '{4'hF, 1'b0, 4'hC, 1'b1, 2, 1'b1, 3, 9};
    vecs[6]  = '{4'hF, 1'b0, 4'h3, 1'b1, 0, 1'b1, 1, 7};
    vecs[7]  = '{4'hF, 1'b0, 4'hC, 1'b1, 2, 1'b1, 3, 5};
    vecs[8]  = '{4'hF, 1'b0, 4'h3, 1'b1, 0, 1'b1, 1, 3};
    vecs[9]  = '{4'hF, 1'b0, 4'hC, 1'b1, 2, 1'b1, 3, 1};
    vecs[10] = '{4'hF, 1'b0, 4'h1, 1'b1, 0, 1'b0, 0, 0};
    vecs[11] = '{4'hF, 1'b0, 4'h0, 1'b0, 0, 1'b0, 0, 0};
    // one dequeue at zero credits: single grant next cycle on A
    vecs[12] = '{4'hF, 1'b1, 4'h0, 1'b0, 0, 1'b0, 0, 1};
    vecs[13] = '{4'hF, 1'b0, 4'h2, 1'b1, 1, 1'b0, 0, 0};
    // refill to 5 credits
    vecs[14] = '{4'h0, 1'b1, 4'h0, 1'b0, 0, 1'b0, 0, 1};
    vecs[15] = '{4'h0, 1'b1, 4'h0, 1'b0, 0, 1'b0, 0, 2};
    vecs[16] = '{4'h0, 1'b1, 4'h0, 1'b0, 0, 1'b0, 0, 3};
    vecs[17] = '{4'h0, 1'b1, 4'h0, 1'b0, 0, 1'b0, 0, 4};
    vecs[18] = '{4'h0, 1'b1, 4'h0, 1'b0, 0, 1'b0, 0, 5};
    // two grants plus dequeue at 5 credits
    vecs[19] = '{4'hF, 1'b1, 4'hC, 1'b1, 2, 1'b1, 3, 4};

    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = dat(i);
    rst = 1'b1;
    req_valid = 4'hF;
    deq_fire = 1'b0;
    fifo_in_valid = 1'b1;
    #12;
    check("rst_credits", 64'(credits), 64'(QS));
    check("rst_a_en", 64'(inA_enque_en), 64'd0);
    check("rst_b_en", 64'(inB_enque_en), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_total", 64'(enq_total), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_a_data", inA_data, 64'd0);
    req_valid = 4'h0;
    #10;
    rst = 1'b0;
    step();
    check("idle_credits", 64'(credits), 64'(QS));
    check("idle_a_en", 64'(inA_enque_en), 64'd0);

    for (int v = 0; v < 20; v++) begin
      req_valid = vecs[v].rv;
      deq_fire  = vecs[v].deq;
      #4;
      check($sformatf("v%0d_ready", v), 64'(req_ready), 64'(vecs[v].exp_ready));
      step();
      check($sformatf("v%0d_a_en", v), 64'(inA_enque_en), 64'(vecs[v].exp_a));
      check($sformatf("v%0d_b_en", v), 64'(inB_enque_en), 64'(vecs[v].exp_b));
      check($sformatf("v%0d_credits", v), 64'(credits), 64'(vecs[v].exp_cr));
      if (vecs[v].exp_a) check($sformatf("v%0d_a_data", v), inA_data, dat(vecs[v].a_idx));
      if (vecs[v].exp_b) check($sformatf("v%0d_b_data", v), inB_data, dat(vecs[v].b_idx));
      check($sformatf("v%0d_err", v), 64'(err), 64'd0);
      if (v == 11) check("burst_total", 64'(enq_total), 64'd21);
    end
    check("total_22", 64'(enq_total), 64'd22);

    // refill to full credits
    req_valid = 4'h0;
    deq_fire  = 1'b1;
    step();
    check("total_24", 64'(enq_total), 64'd24);
    for (int n = 0; n < 16; n++) step();
    check("full_credits", 64'(credits), 64'(QS));
    check("full_err", 64'(err), 64'd0);

    // dequeue report with full pool
    step();
    check("unf_err", 64'(err), 64'd2);
    check("unf_credits", 64'(credits), 64'(QS));

    // strobe presented while FIFO not accepting
    deq_fire = 1'b0;
    fifo_in_valid = 1'b0;
    req_valid = 4'h1;
    #4;
    check("single_ready", 64'(req_ready), 64'h1);
    step();
    check("single_a_en", 64'(inA_enque_en), 64'd1);
    check("single_b_en", 64'(inB_enque_en), 64'd0);
    check("single_a_data", inA_data, dat(0));
    check("single_credits", 64'(credits), 64'd20);
    req_valid = 4'h0;
    step();
    check("ovf_err", 64'(err), 64'd3);
    check("total_25", 64'(enq_total), 64'd25);
    fifo_in_valid = 1'b1;

    // reset mid-burst with strobes pending
    req_valid = 4'hF;
    #4;
    check("pre_rst_ready", 64'(req_ready), 64'h6);
    step();
    check("pre_rst_a_en", 64'(inA_enque_en), 64'd1);
    check("pre_rst_b_en", 64'(inB_enque_en), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_a_en", 64'(inA_enque_en), 64'd0);
    check("mid_rst_b_en", 64'(inB_enque_en), 64'd0);
    check("mid_rst_credits", 64'(credits), 64'(QS));
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_total", 64'(enq_total), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    req_valid = 4'h0;
    #2;
    rst = 1'b0;
    step();
    check("post_rst_total", 64'(enq_total), 64'd0);
    req_valid = 4'hF;
    #4;
    check("post_rst_ready", 64'(req_ready), 64'h3);
    step();
    check("post_rst_a_data", inA_data, dat(0));
    check("post_rst_b_data", inB_data, dat(1));
    check("post_rst_total1", 64'(enq_total), 64'd0);
    req_valid = 4'h0;
    step();
    check("post_rst_total2", 64'(enq_total), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
